// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial sequence detector.
// Holds the FSM state encoding, reset defaults and the fill counter width helper.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_e;

    localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1011;
    localparam logic       SEQ_DEF_OVERLAP = 1'b1;

    function automatic int fill_w(input int seq_w);
        return $clog2(seq_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with a clear input that takes priority over increment.
// Holds at all-ones instead of wrapping.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with a programmable pattern, overlap select,
// valid qualifier and a saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               SEQ_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [SEQ_W-1:0] DEF_PATTERN = SEQ_W'(SEQ_DEF_PATTERN),
    parameter logic             DEF_OVERLAP = SEQ_DEF_OVERLAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [SEQ_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             serial_in,
    input  logic             serial_vld,
    input  logic             cnt_clr,
    output logic             seq_det_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam int FW = fill_w(SEQ_W);

    det_state_e       state_q, state_d;
    logic [SEQ_W-1:0] hist_q, hist_d, hist_nx;
    logic [SEQ_W-1:0] pattern_q, pattern_d;
    logic             overlap_q, overlap_d;
    logic [FW-1:0]    fill_q, fill_d, fill_inc;
    logic             det_q, hit;

    assign hist_nx  = {hist_q[SEQ_W-2:0], serial_in};
    assign fill_inc = fill_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        fill_d    = fill_q;
        hit       = 1'b0;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = FILL;
        end else if (serial_vld) begin
            hist_d = hist_nx;
            unique case (state_q)
                FILL: begin
                    fill_d = fill_inc;
                    if (fill_inc == FW'(SEQ_W)) begin
                        hit     = (hist_nx == pattern_q);
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    hit = (hist_nx == pattern_q);
                end
                default: state_d = FILL;
            endcase
            // Non-overlap: the next match must be built from fresh bits only.
            if (hit && !overlap_q) begin
                fill_d  = '0;
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            hist_q    <= '0;
            pattern_q <= DEF_PATTERN;
            overlap_q <= DEF_OVERLAP;
            fill_q    <= '0;
            det_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            fill_q    <= fill_d;
            det_q     <= hit;
        end
    end

    seq_det_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (hit),
        .clr  (cnt_clr),
        .cnt_o(match_cnt_o)
    );

    assign seq_det_o = det_q;

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial sequence detector, successor to the fixed-pattern single-bit detector. It adds:
- a runtime-programmable pattern of SEQ_W bits
- an overlap / non-overlap mode select
- an input valid qualifier
- a saturating match counter

It sits on a serial bitstream input and raises a one-cycle detect pulse toward downstream control logic.

Parameters:
SEQ_W, 4, pattern length in bits (>=2)
CNT_W, 8, match counter width (>=1)
DEF_PATTERN, 4'b1011 (SEQ_W bits), pattern loaded at reset
DEF_OVERLAP, 1'b1, overlap mode loaded at reset

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cfg_load  input  1  load cfg_pattern/cfg_overlap this cycle
cfg_pattern  input  SEQ_W  new pattern; MSB = earliest received bit
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
serial_in  input  1  serial data bit
serial_vld  input  1  serial_in is valid this cycle
cnt_clr  input  1  clear match counter
seq_det_o  output  1  one-cycle pulse on pattern match
match_cnt_o  output  CNT_W  saturating count of matches

Behaviour:
Clock and reset:
- One clock, clk. reset is synchronous and active-high.
- On reset: pattern_q=DEF_PATTERN, overlap_q=DEF_OVERLAP, hist=0, fill_cnt=0, state=FILL, seq_det_o=0, match_cnt_o=0.
- reset overrides every other input.

Bit acceptance:
- A bit is accepted at a rising edge when serial_vld=1, cfg_load=0 and reset=0.
- hist shifts left with serial_in entering the LSB: hist <= {hist[SEQ_W-2:0], serial_in}.
- Cycles with serial_vld=0 leave hist, fill_cnt and state unchanged.

FSM (registered state):
- FILL: each accepted bit increments fill_cnt. When an accepted bit brings fill_cnt to SEQ_W, compare the new hist value to pattern_q in that same edge, then go to ARMED.
- ARMED: every accepted bit compares the new hist value to pattern_q.
- On a match in non-overlap mode (overlap_q=0): fill_cnt <= 0, state <= FILL. The next match needs SEQ_W fresh bits.
- On a match in overlap mode: stay in ARMED.

Detect output:
- seq_det_o is registered. It is 1 for exactly one cycle following the edge that accepted the completing bit (one-cycle latency from serial_in presentation).
- It is 0 in all other cycles, including cycles with serial_vld=0.

Configuration load (cfg_load=1):
- pattern_q <= cfg_pattern, overlap_q <= cfg_overlap, hist <= 0, fill_cnt <= 0, state <= FILL, seq_det_o <= 0.
- serial_in is discarded that cycle.
- match_cnt_o is not affected.

Match counter:
- Increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
- If cnt_clr=1 and a match occur on the same edge, cnt_clr wins: count=0, but seq_det_o still pulses.
- cnt_clr does not touch the FSM.

Width rules: fill_cnt is $clog2(SEQ_W+1) bits and never exceeds SEQ_W.

Reset mid-operation: a partially received pattern is discarded, and any pending detect is squashed (seq_det_o=0 in the cycle after reset).

Decomposition:
- Shared package seq_det_pkg holds:
  - the state enum (FILL=1'b0, ARMED=1'b1)
  - the default pattern / overlap constants
  - a function returning fill_cnt width from SEQ_W
- One sub-module, seq_det_sat_cnt: a CNT_W saturating counter with inc and clr inputs, clr priority.
- The shift/FSM/compare logic stays in the top module.

Test Plan:
1. Overlap mode, pattern 1011, serial_vld=1, bits 1,0,1,1,0,1,1 -> seq_det_o pulses after the 4th and 7th bits; match_cnt_o=2.
2. cfg_load pattern 1011, cfg_overlap=0, same stream -> single pulse after the 4th bit; match_cnt_o=1 (bits 5-7 give only 3 fresh bits).
3. Stream 1,0,1,1 with serial_vld=0 gaps of 2 cycles between bits -> exactly one pulse, in the cycle after the 4th valid bit; no pulse during gaps.
4. CNT_W=2, overlap pattern 11 (SEQ_W=2), six 1s -> 5 pulses, match_cnt_o sticks at 3. Then cnt_clr coincident with a match -> match_cnt_o=0 and seq_det_o=1.
5. Bits 1,0,1, then reset for 1 cycle, then bit 1 -> no pulse; counter 0; state FILL with fill_cnt=1.
6. Bits 1,0,1, then cfg_load with pattern 0101 on the 4th cycle (serial_in=1 discarded), then 0,1,0,1 -> single pulse after the final 1; earlier partial history ignored.
